config_adder_tree_sequencer: RTL and testbench
==============================================

# config_adder_tree_sequencer

Iterative reduction controller for the configurable adder-tree layer. It accepts one vector of `INPUTS_AMOUNT` signed operands and owns a single internal `config_adder_tree_layer` instance, feeding that layer's outputs back through a register bank for `log2(INPUTS_AMOUNT)` passes. The result is one full-precision sum or two packed half-precision sums. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `INPUTS_AMOUNT`, default 8: operands per vector; power of 2, ≥2.
- `P`, default 8: operand width in bits; even.
- `LOG2N` (localparam) = `$clog2(INPUTS_AMOUNT)`.
- `ACC_W` (localparam) = `P + 2*LOG2N`: width of the accumulator registers and the result.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset; synchronous, active-high.
- `in_valid_i`, input, 1: operand vector valid.
- `in_ready_o`, output, 1: block can accept a vector.
- `in_data_i`, input, `[P-1:0]` x `INPUTS_AMOUNT`: operands in 2's complement. In halved mode each operand packs two `P/2`-bit values as {upper, lower}.
- `halved_precision_i`, input, 1: mode for the vector; sampled only on the input handshake.
- `out_valid_o`, output, 1: result valid.
- `out_ready_i`, input, 1: consumer accepts the result.
- `out_data_o`, output, `ACC_W`: result. In halved mode it is two packed `ACC_W/2`-bit sums as {upper, lower}.
- `busy_o`, output, 1: high in REDUCE or DONE.

## Operation
- Storage: register bank `acc[INPUTS_AMOUNT]` of `ACC_W` bits, pass counter of `LOG2N` bits, latched mode bit.
- Internal layer: instantiated with `P=ACC_W`, fed from `acc`, with the latched mode on its `halvedPrecision` input.
- States:
  - IDLE → REDUCE on `in_valid_i && in_ready_o`.
  - REDUCE → DONE after exactly `LOG2N` passes.
  - DONE → IDLE on `out_ready_i`.
- Load (input handshake):
  - Full mode: `acc[i]` = sign-extend(`in_data_i[i]`) to `ACC_W`.
  - Halved mode: each `P/2` half is sign-extended to `ACC_W/2` and the two are repacked {upper, lower}.
  - Mode is latched and the pass counter cleared.
- Each REDUCE cycle:
  - For `i < INPUTS_AMOUNT/2`: `acc[i]` <= repacked layer output `i`.
  - For `i ≥ INPUTS_AMOUNT/2`: `acc[i]` <= 0.
  - Pass counter increments.
- Repacking the `ACC_W+2`-bit layer output:
  - Full mode: take the low `ACC_W` bits.
  - Halved mode: the output halves are `[ACC_W+1:ACC_W/2+1]` and `[ACC_W/2:0]`. Keep the low `ACC_W/2` bits of each half.
  - No overflow is possible, because the widths are sized for `LOG2N` levels of growth.
- DONE: `out_data_o` = `acc[0]`. It stays stable while `out_valid_o` is high and `out_ready_i` is low.
- `in_ready_o` = (state == IDLE). There is no overlap of vectors.
- `halved_precision_i` changing outside a handshake has no effect.

## Timing
- Reset values: state IDLE, `in_ready_o`=1, `out_valid_o`=0, `busy_o`=0, `out_data_o`=0, all `acc` and the counter 0.
- Input handshake on edge t:
  - REDUCE occupies cycles t+1 … t+LOG2N.
  - `out_valid_o` rises after edge t+LOG2N and is visible in cycle t+LOG2N+1.
  - Latency is `LOG2N+1` cycles from accept to result valid.
- Output handshake on edge u: IDLE in cycle u+1. The next vector can be accepted at edge u+1.
- Minimum initiation interval: `LOG2N+2` cycles.
- `in_valid_i` held high during REDUCE/DONE: the vector is not consumed and is accepted in the first IDLE cycle.
- `rst_i` high in any state: all of the above reset values apply on the next edge and the in-flight vector is discarded. Reset has priority over simultaneous handshakes.
- `out_valid_o` does not depend combinationally on `out_ready_i`, and `in_ready_o` does not depend on `in_valid_i`.

## Test plan
All scenarios use `INPUTS_AMOUNT`=4, `P`=8 (`ACC_W`=12, `LOG2N`=2).
- Full, positive: operands {1,2,3,4} accepted at edge 0 → `out_valid_o` high in cycle 3 with `out_data_o`=12'h00A. `in_ready_o` is low in cycles 1–3.
- Full, negative extreme: 4×8'h80 (−128) → 12'hE00 (−512). A follow-on mix {127,−1,−128,5} → 12'h003.
- Halved: 4×8'h78 (upper 7, lower −8) → upper 28, lower −32 → `out_data_o`=12'h720. A mode toggle on `halved_precision_i` mid-REDUCE does not change the result.
- Backpressure: hold `out_ready_i` low for 5 cycles in DONE while driving `in_valid_i` high → `out_data_o` stable, `in_ready_o` low. After `out_ready_i`, the pending vector is accepted one cycle later.
- Reset mid-REDUCE: assert `rst_i` in cycle 1 after accept → next cycle IDLE, `out_valid_o`=0, `in_ready_o`=1, `out_data_o`=0. A fresh vector then completes with the correct sum.
- Back-to-back: `out_ready_i` tied high with 3 queued vectors → results every 4 cycles, each correct.

Source files
------------

// File: rtl/config_adder_tree_sequencer.sv
// rtl/config_adder_tree_sequencer.sv - iterative reduction controller around a configurable adder-tree layer
//
// config_adder_tree_layer: one level of pairwise adds, full or two packed halves.
//   halvedPrecision : 1 = each operand is {upper, lower} of P/2 bits each
//   data_i          : INPUTS_AMOUNT operands, P bits each
//   data_o          : INPUTS_AMOUNT/2 sums, P+2 bits each ({upper, lower} of P/2+1 bits in halved mode)
//
// config_adder_tree_sequencer: loads one operand vector, runs LOG2N passes, presents the sum.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_valid_i / in_ready_o : operand vector handshake, in_data_i + halved_precision_i
//   out_valid_o / out_ready_i : result handshake, out_data_o (ACC_W bits)
//   busy_o                  : reduction in flight or result waiting

module config_adder_tree_layer #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 8
) (
  input  logic           halvedPrecision,
  input  logic [P-1:0]   data_i [INPUTS_AMOUNT],
  output logic [P+1:0]   data_o [INPUTS_AMOUNT/2]
);
  localparam int H = P / 2;

  for (genvar g = 0; g < INPUTS_AMOUNT / 2; g++) begin : g_pair
    logic [P-1:0] a;
    logic [P-1:0] b;
    logic [P+1:0] full_sum;
    logic [H:0]   hi_sum;
    logic [H:0]   lo_sum;

    assign a        = data_i[2*g];
    assign b        = data_i[2*g+1];
    assign full_sum = {{2{a[P-1]}}, a} + {{2{b[P-1]}}, b};
    assign hi_sum   = {a[P-1], a[P-1:H]} + {b[P-1], b[P-1:H]};
    assign lo_sum   = {a[H-1], a[H-1:0]} + {b[H-1], b[H-1:0]};
    assign data_o[g] = halvedPrecision ? {hi_sum, lo_sum} : full_sum;
  end
endmodule

module config_adder_tree_sequencer #(
  parameter  int INPUTS_AMOUNT = 8,
  parameter  int P             = 8,
  localparam int LOG2N         = $clog2(INPUTS_AMOUNT),
  localparam int ACC_W         = P + 2 * LOG2N
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [P-1:0]     in_data_i [INPUTS_AMOUNT],
  input  logic             halved_precision_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic             busy_o
);
  localparam int HW     = ACC_W / 2;
  localparam int HALF_N = INPUTS_AMOUNT / 2;
  localparam logic [LOG2N-1:0] LAST_PASS = LOG2N'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc      [INPUTS_AMOUNT];
  logic [ACC_W-1:0] loaded   [INPUTS_AMOUNT];
  logic [ACC_W+1:0] layer_out [HALF_N];
  logic [ACC_W-1:0] repacked [HALF_N];
  logic [LOG2N-1:0] pass_cnt;
  logic             mode_q;
  logic             in_fire;
  logic             unused_layer_msbs;

  assign in_fire = in_valid_i && (state == IDLE);

  config_adder_tree_layer #(
    .INPUTS_AMOUNT (INPUTS_AMOUNT),
    .P             (ACC_W)
  ) u_layer (
    .halvedPrecision (mode_q),
    .data_i          (acc),
    .data_o          (layer_out)
  );

  // Operand load: full mode sign-extends the whole operand, halved mode
  // sign-extends each P/2 half into its own ACC_W/2 lane.
  for (genvar g = 0; g < INPUTS_AMOUNT; g++) begin : g_load
    assign loaded[g] = halved_precision_i
      ? {{LOG2N{in_data_i[g][P-1]}},   in_data_i[g][P-1:P/2],
         {LOG2N{in_data_i[g][P/2-1]}}, in_data_i[g][P/2-1:0]}
      : {{(2*LOG2N){in_data_i[g][P-1]}}, in_data_i[g]};
  end

  // The layer grows each lane by one bit; the accumulator width already
  // covers all LOG2N levels, so the carry bit of each lane is dropped.
  for (genvar g = 0; g < HALF_N; g++) begin : g_repack
    assign repacked[g] = mode_q
      ? {layer_out[g][ACC_W:HW+1], layer_out[g][HW-1:0]}
      : layer_out[g][ACC_W-1:0];
  end

  // The top carry bit is never needed in either mode.
  always_comb begin
    unused_layer_msbs = 1'b0;
    for (int i = 0; i < HALF_N; i++) begin
      unused_layer_msbs = unused_layer_msbs ^ layer_out[i][ACC_W+1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_i)             state_nxt = REDUCE;
      REDUCE:  if (pass_cnt == LAST_PASS)  state_nxt = DONE;
      DONE:    if (out_ready_i)            state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == IDLE);
    out_valid_o = (state == DONE);
    busy_o      = (state == REDUCE) || (state == DONE);
    out_data_o  = (state == DONE) ? acc[0] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        acc[i] <= '0;
      end
      pass_cnt <= '0;
      mode_q   <= 1'b0;
    end else if (in_fire) begin
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        acc[i] <= loaded[i];
      end
      pass_cnt <= '0;
      mode_q   <= halved_precision_i;
    end else if (state == REDUCE) begin
      for (int i = 0; i < HALF_N; i++) begin
        acc[i] <= repacked[i];
      end
      for (int i = HALF_N; i < INPUTS_AMOUNT; i++) begin
        acc[i] <= '0;
      end
      pass_cnt <= pass_cnt + LOG2N'(1);
    end
  end
endmodule

// File: tb/tb_config_adder_tree_sequencer.sv
// tb/tb_config_adder_tree_sequencer.sv - self-checking bench for config_adder_tree_sequencer
module tb_config_adder_tree_sequencer;
  localparam int N     = 4;
  localparam int P     = 8;
  localparam int ACC_W = 12;

  typedef struct {
    logic [N-1:0][P-1:0] data;
    logic                halved;
    logic [ACC_W-1:0]    exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [P-1:0]     in_data [N];
  logic             halved;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  logic [ACC_W-1:0] sb[$];
  int               res_cyc[$];
  logic [ACC_W-1:0] cur_exp;
  vec_t             tbl[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  config_adder_tree_sequencer #(.INPUTS_AMOUNT(N), .P(P)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_data_i          (in_data),
    .halved_precision_i (halved),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_data_o         (out_data),
    .busy_o             (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Handshakes are decided on the next rising edge; inputs and outputs are
  // stable at the falling edge, so the scoreboard is driven from there.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h, expected no result", out_data);
      end else begin
        check("result", out_data, sb.pop_front());
      end
      res_cyc.push_back(cyc);
    end
    if (!rst && in_valid && in_ready) sb.push_back(cur_exp);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [ACC_W-1:0] model(input logic [N-1:0][P-1:0] d, input logic h);
    int sf = 0, su = 0, sl = 0;
    logic signed [P-1:0]   f;
    logic signed [P/2-1:0] u, l;
    for (int i = 0; i < N; i++) begin
      f = d[i];
      u = d[i][P-1:P/2];
      l = d[i][P/2-1:0];
      sf += int'(f);
      su += int'(u);
      sl += int'(l);
    end
    if (h) return {su[ACC_W/2-1:0], sl[ACC_W/2-1:0]};
    return sf[ACC_W-1:0];
  endfunction

  task automatic set_vec(input logic [N-1:0][P-1:0] d, input logic h, input logic [ACC_W-1:0] e);
    for (int i = 0; i < N; i++) in_data[i] = d[i];
    halved  = h;
    cur_exp = e;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [N-1:0][P-1:0] d, input logic h, input logic [ACC_W-1:0] e);
    int k = 0;
    set_vec(d, h, e);
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_in_time", k < 50, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [N-1:0][P-1:0] d;
    int k;

    tbl[0] = '{data: {8'd4, 8'd3, 8'd2, 8'd1},         halved: 1'b0, exp: 12'h00A};
    tbl[1] = '{data: {4{8'h80}},                       halved: 1'b0, exp: 12'hE00};
    tbl[2] = '{data: {8'h05, 8'h80, 8'hFF, 8'h7F},     halved: 1'b0, exp: 12'h003};
    tbl[3] = '{data: {4{8'h78}},                       halved: 1'b1, exp: 12'h720};
    tbl[4] = '{data: {4{8'h00}},                       halved: 1'b0, exp: 12'h000};
    tbl[5] = '{data: {4{8'h7F}},                       halved: 1'b0, exp: 12'h1FC};
    tbl[6] = '{data: {4{8'h88}},                       halved: 1'b1, exp: 12'h820};
    tbl[7] = '{data: {4{8'h7F}},                       halved: 1'b1, exp: 12'h73C};
    tbl[8] = '{data: {4{8'h80}},                       halved: 1'b1, exp: 12'h800};
    tbl[9] = '{data: {4{8'hFF}},                       halved: 1'b0, exp: 12'hFFC};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; halved = 1'b0; cur_exp = '0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    // Latency: accept at edge 0, result visible in cycle 3.
    set_vec({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 12'h00A);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      check("lat_in_ready_low", in_ready, 0);
      check("lat_out_valid_low", out_valid, 0);
      check("lat_busy", busy, 1);
      @(posedge clk); #1;
    end
    check("lat_out_valid_c3", out_valid, 1);
    check("lat_in_ready_c3", in_ready, 0);
    check("lat_out_data_c3", out_data, 12'h00A);
    @(posedge clk); #1;
    check("lat_idle_ready", in_ready, 1);
    check("lat_idle_valid", out_valid, 0);
    wait_drain();

    // Mode and data changes during REDUCE must not disturb the result.
    send({4{8'h78}}, 1'b1, 12'h720);
    halved = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = 8'h11;
    @(posedge clk); #1;
    halved = 1'b1;
    wait_drain();

    // Backpressure with a pending vector.
    out_ready = 1'b0;
    send({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 12'h00A);
    set_vec({4{8'h80}}, 1'b0, 12'hE00);
    in_valid = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_data_stable", out_data, 12'h00A);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    @(posedge clk); #1;
    check("bp_pending_accepted", busy, 1);
    in_valid = 1'b0;
    wait_drain();

    // Reset in the first REDUCE cycle discards the vector.
    set_vec({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 12'h00A);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    send({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0, 12'h064);
    wait_drain();

    // Table of directed vectors.
    for (int t = 0; t < 10; t++) begin
      send(tbl[t].data, tbl[t].halved, tbl[t].exp);
      wait_drain();
    end

    // Back-to-back random vectors, out_ready tied high: one result every 4 cycles.
    res_cyc.delete();
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) d[i] = P'($urandom);
      k = int'($urandom_range(0, 1));
      send(d, k[0], model(d, k[0]));
    end
    wait_drain();
    check("b2b_count", res_cyc.size(), 20);
    for (int i = 1; i < res_cyc.size(); i++) begin
      check("b2b_interval", res_cyc[i] - res_cyc[i-1], 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
